// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: Vdp display fetch has priority, and a starvation
// counter forces a CPU slot. Read data returns one cycle after grant with a valid strobe.
module vram_arbiter #(
  parameter int unsigned ADDR_WIDTH       = 16,
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned CPU_STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vdp_req,
  input  logic [ADDR_WIDTH-1:0] vdp_addr,
  output logic                  vdp_gnt,
  output logic                  vdp_rvalid,
  output logic [DATA_WIDTH-1:0] vdp_rdata,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int unsigned CntWidth = $clog2(CPU_STARVE_LIMIT + 1);

  typedef enum logic [1:0] {OwnNone, OwnVdp, OwnCpu} owner_e;

  owner_e                rd_owner;
  logic [CntWidth-1:0]   starve_cnt;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic [DATA_WIDTH-1:0] vdp_rdata_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic                  force_cpu;

  assign force_cpu = (starve_cnt == CntWidth'(CPU_STARVE_LIMIT));

  always_comb begin
    vdp_gnt = 1'b0;
    cpu_gnt = 1'b0;
    if (!reset) begin
      if (cpu_req && (!vdp_req || force_cpu)) begin
        cpu_gnt = 1'b1;
      end else if (vdp_req) begin
        vdp_gnt = 1'b1;
      end
    end
  end

  // With no winner the RAM bus parks on the last driven address/data.
  always_comb begin
    ram_addr  = ram_addr_q;
    ram_wdata = ram_wdata_q;
    if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (vdp_gnt) begin
      ram_addr = vdp_addr;
    end
  end

  assign ram_we = cpu_gnt & cpu_we;

  // A read granted just before reset must not surface while reset is held.
  assign vdp_rvalid = (rd_owner == OwnVdp) && !reset;
  assign cpu_rvalid = (rd_owner == OwnCpu) && !reset;

  // The RAM read is registered, so ram_rdata lines up with the owner register.
  assign vdp_rdata = vdp_rvalid ? ram_rdata : vdp_rdata_q;
  assign cpu_rdata = cpu_rvalid ? ram_rdata : cpu_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner    <= OwnNone;
      starve_cnt  <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      vdp_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      ram_addr_q  <= ram_addr;
      ram_wdata_q <= ram_wdata;

      if (cpu_req && !cpu_gnt) begin
        if (!force_cpu) begin
          starve_cnt <= starve_cnt + CntWidth'(1);
        end
      end else begin
        starve_cnt <= '0;
      end

      if (vdp_gnt) begin
        rd_owner <= OwnVdp;
      end else if (cpu_gnt && !cpu_we) begin
        rd_owner <= OwnCpu;
      end else begin
        rd_owner <= OwnNone;
      end

      if (vdp_rvalid) begin
        vdp_rdata_q <= ram_rdata;
      end
      if (cpu_rvalid) begin
        cpu_rdata_q <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a registered-read RAM model and a read-return
// scoreboard keyed on the cycle each rvalid is due.
module tb_vram_arbiter;

  logic        clk;
  logic        reset;
  logic        vdp_req;
  logic [15:0] vdp_addr;
  logic        vdp_gnt;
  logic        vdp_rvalid;
  logic [7:0]  vdp_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  vram_arbiter #(
    .ADDR_WIDTH      (16),
    .DATA_WIDTH      (8),
    .CPU_STARVE_LIMIT(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .vdp_req   (vdp_req),
    .vdp_addr  (vdp_addr),
    .vdp_gnt   (vdp_gnt),
    .vdp_rvalid(vdp_rvalid),
    .vdp_rdata (vdp_rdata),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37) ^ 8'h5A);
  endfunction

  // RAM with registered read, 256 locations are enough for this bench.
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[7:0]];
  end

  typedef struct {
    logic       is_cpu;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_mem [0:255];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Checks grants and the scoreboard at the falling edge, then records new reads.
  task automatic sample(input logic exp_vg, input logic exp_cg);
    exp_t item;
    @(negedge clk);
    chk("vdp_gnt", {15'd0, vdp_gnt}, {15'd0, exp_vg});
    chk("cpu_gnt", {15'd0, cpu_gnt}, {15'd0, exp_cg});
    if (sb.size() > 0 && sb[0].due == cyc) begin
      item = sb.pop_front();
      chk("vdp_rvalid", {15'd0, vdp_rvalid}, {15'd0, !item.is_cpu});
      chk("cpu_rvalid", {15'd0, cpu_rvalid}, {15'd0, item.is_cpu});
      if (item.is_cpu) chk("cpu_rdata", {8'd0, cpu_rdata}, {8'd0, item.data});
      else             chk("vdp_rdata", {8'd0, vdp_rdata}, {8'd0, item.data});
    end else begin
      chk("vdp_rvalid_idle", {15'd0, vdp_rvalid}, 16'd0);
      chk("cpu_rvalid_idle", {15'd0, cpu_rvalid}, 16'd0);
    end
    if (exp_vg) begin
      chk("ram_addr_vdp", ram_addr, vdp_addr);
      sb.push_back('{is_cpu: 1'b0, data: model_mem[vdp_addr[7:0]], due: cyc + 1});
    end
    if (exp_cg) begin
      chk("ram_addr_cpu", ram_addr, cpu_addr);
      chk("ram_we_cpu", {15'd0, ram_we}, {15'd0, cpu_we});
      if (cpu_we) model_mem[cpu_addr[7:0]] = cpu_wdata;
      else sb.push_back('{is_cpu: 1'b1, data: model_mem[cpu_addr[7:0]], due: cyc + 1});
    end
    if (!exp_cg) chk("ram_we_idle", {15'd0, ram_we}, 16'd0);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]       = pat(i);
      model_mem[i] = pat(i);
    end
    reset     = 1'b1;
    vdp_req   = 1'b0;
    vdp_addr  = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;

    // Reset state; requests during reset must not be granted.
    sample(1'b0, 1'b0);
    chk("rst_ram_addr", ram_addr, 16'h0000);
    chk("rst_ram_wdata", {8'd0, ram_wdata}, 16'h0000);
    chk("rst_vdp_rdata", {8'd0, vdp_rdata}, 16'h0000);
    chk("rst_cpu_rdata", {8'd0, cpu_rdata}, 16'h0000);
    adv();
    vdp_req = 1'b1;
    cpu_req = 1'b1;
    sample(1'b0, 1'b0);
    adv();
    vdp_req = 1'b0;
    cpu_req = 1'b0;
    reset   = 1'b0;

    // 1: CPU write, no rvalid afterwards.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'hA5;
    sample(1'b0, 1'b1);
    chk("t1_ram_we", {15'd0, ram_we}, 16'd1);
    chk("t1_ram_wdata", {8'd0, ram_wdata}, 16'h00A5);
    adv();
    cpu_req = 1'b0; cpu_we = 1'b0;
    sample(1'b0, 1'b0);
    chk("t1_ram_addr_hold", ram_addr, 16'h0010);
    adv();

    // 2: CPU read-back of the written byte; rdata holds afterwards.
    cpu_req = 1'b1; cpu_addr = 16'h0010;
    sample(1'b0, 1'b1);
    adv();
    cpu_req = 1'b0;
    sample(1'b0, 1'b0);
    chk("t2_cpu_rdata", {8'd0, cpu_rdata}, 16'h00A5);
    adv();
    sample(1'b0, 1'b0);
    chk("t2_cpu_rdata_hold", {8'd0, cpu_rdata}, 16'h00A5);
    adv();

    // 3: both requesting, CPU forced in on the fifth cycle.
    vdp_req = 1'b1; vdp_addr = 16'h0020;
    cpu_req = 1'b1; cpu_addr = 16'h0030;
    for (int i = 0; i < 6; i++) begin
      sample(i != 4, i == 4);
      adv();
    end
    vdp_req = 1'b0; cpu_req = 1'b0;
    sample(1'b0, 1'b0);
    adv();

    // 4: Vdp burst of four reads.
    for (int i = 0; i < 4; i++) begin
      vdp_req = 1'b1; vdp_addr = 16'(i);
      sample(1'b1, 1'b0);
      adv();
    end
    vdp_req = 1'b0;
    sample(1'b0, 1'b0);
    adv();
    sample(1'b0, 1'b0);
    chk("t4_vdp_rdata_hold", {8'd0, vdp_rdata}, {8'd0, pat(3)});
    adv();

    // 5: build up starvation, then reset right after a Vdp read grant.
    vdp_req = 1'b1; vdp_addr = 16'h0005;
    cpu_req = 1'b1; cpu_addr = 16'h0006;
    sample(1'b1, 1'b0);
    adv();
    sample(1'b1, 1'b0);
    adv();
    reset = 1'b1;
    sb.delete();
    sample(1'b0, 1'b0);
    adv();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample(i < 4, i == 4);
      adv();
    end
    vdp_req = 1'b0; cpu_req = 1'b0;
    sample(1'b0, 1'b0);
    adv();

    // 6: alternate CPU and Vdp reads every cycle.
    for (int i = 0; i < 8; i++) begin
      cpu_req  = (i % 2 == 0);
      vdp_req  = (i % 2 == 1);
      cpu_we   = 1'b0;
      cpu_addr = 16'(16'h0010 + i);
      vdp_addr = 16'(i + 8);
      sample(i % 2 == 1, i % 2 == 0);
      adv();
    end
    vdp_req = 1'b0; cpu_req = 1'b0;
    sample(1'b0, 1'b0);
    adv();
    chk("sb_drained", 16'(sb.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
